trig_taylor: RTL and testbench

Parametrised sin/cos accelerator that evaluates a truncated Taylor series in signed fixed point using one shared multiplier and an iterative term recurrence. It generalises the fixed 16-bit sin(x) datapath/controller pair: configurable width, fraction bits and number of series terms, a runtime sin/cos mode select, and a ready/valid handshake with back-pressure on the result. It sits as a memory-less compute slave between a host sequencer and downstream consumers.

---
 rtl/trig_taylor_pkg.sv | 28 ++
 rtl/trig_taylor_mac.sv | 63 ++++++
 rtl/trig_taylor.sv | 137 +++++++++++++
 tb/tb_trig_taylor.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/trig_taylor_pkg.sv
// rtl/trig_taylor_pkg.sv - shared types, limits and reciprocal constants for trig_taylor
package trig_taylor_pkg;

  localparam int MAX_TERMS = 8;
  localparam int KW        = $clog2(MAX_TERMS);

  typedef enum logic [2:0] {IDLE, SQ, MULX, MULR, ACC, DONE} state_t;

  typedef enum logic {MODE_SIN = 1'b0, MODE_COS = 1'b1} mode_t;

  typedef enum logic [2:0] {
    OP_HOLD,
    OP_LOAD,
    OP_MULX,
    OP_MULR,
    OP_ADD,
    OP_SUB
  } mac_op_t;

  // Rounded Q.frac value of the k-th term ratio; k = 0 has no ratio and yields 0.
  function automatic int recip(input logic mode, input int k, input int frac);
    int d;
    d = mode ? (2 * k - 1) * (2 * k) : (2 * k) * (2 * k + 1);
    if (k < 1 || d == 0) return 0;
    return ((1 << frac) + d / 2) / d;
  endfunction

endpackage

// File: rtl/trig_taylor_mac.sv
// rtl/trig_taylor_mac.sv - shared multiplier with x2/term/sum registers for the series recurrence
module trig_taylor_mac
  import trig_taylor_pkg::*;
#(
  parameter int IW   = 20,
  parameter int FRAC = 14
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic [2:0]           op_i,
  input  logic signed [IW-1:0] x_i,
  input  logic signed [IW-1:0] init_i,
  input  logic signed [IW-1:0] coef_i,
  output logic signed [IW-1:0] sum_o
);

  logic signed [IW-1:0]   x2_q;
  logic signed [IW-1:0]   term_q;
  logic signed [IW-1:0]   sum_q;
  logic signed [IW-1:0]   op_a;
  logic signed [IW-1:0]   op_b;
  logic signed [IW-1:0]   mul_res;
  logic signed [2*IW-1:0] prod;

  // Operand mux: the single multiplier serves x*x, term*x2 and term*coef.
  always_comb begin
    op_a = term_q;
    op_b = x2_q;
    case (op_i)
      OP_LOAD: begin
        op_a = x_i;
        op_b = x_i;
      end
      OP_MULR: op_b = coef_i;
      default: ;
    endcase
    prod    = (2*IW)'(op_a) * (2*IW)'(op_b);
    mul_res = IW'(prod >>> FRAC);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      x2_q   <= '0;
      term_q <= '0;
      sum_q  <= '0;
    end else begin
      case (op_i)
        OP_LOAD: begin
          x2_q   <= mul_res;
          term_q <= init_i;
          sum_q  <= init_i;
        end
        OP_MULX, OP_MULR: term_q <= mul_res;
        OP_ADD:           sum_q  <= sum_q + term_q;
        OP_SUB:           sum_q  <= sum_q - term_q;
        default: ;
      endcase
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/trig_taylor.sv
// rtl/trig_taylor.sv - iterative Taylor-series sin/cos unit with ready/valid handshake
module trig_taylor
  import trig_taylor_pkg::*;
#(
  parameter int W      = 16,
  parameter int FRAC   = 14,
  parameter int NTERMS = 4,
  parameter int GUARD  = 4
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  input  logic         start_i,
  input  logic         mode_i,
  input  logic [W-1:0] x_i,
  output logic         ready_o,
  output logic [W-1:0] result_o,
  output logic         valid_o,
  input  logic         ready_i
);

  localparam int IW    = W + GUARD;
  localparam int ONE_I = 1 << FRAC;
  localparam logic signed [IW-1:0] ONE    = IW'(ONE_I);
  localparam logic signed [IW-1:0] SAT_HI = {{(GUARD+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [IW-1:0] SAT_LO = {{(GUARD+1){1'b1}}, {(W-1){1'b0}}};
  localparam logic [KW-1:0]        K_LAST = KW'(NTERMS - 1);

  if (NTERMS < 2 || NTERMS > MAX_TERMS || FRAC >= W) begin : g_bad_cfg
    $error("trig_taylor: NTERMS must be 2..MAX_TERMS and FRAC below W");
  end

  state_t               state_q;
  state_t               state_d;
  mode_t                mode_q;
  logic signed [W-1:0]  x_q;
  logic [KW-1:0]        k_q;
  logic                 valid_q;
  logic [W-1:0]         result_q;
  logic [2:0]           mac_op;
  logic signed [IW-1:0] x_ext;
  logic signed [IW-1:0] init_val;
  logic signed [IW-1:0] coef;
  logic signed [IW-1:0] sum;
  logic [W-1:0]         sat_val;

  logic signed [IW-1:0] recip_tab [2][MAX_TERMS];

  for (genvar m = 0; m < 2; m++) begin : g_rm
    for (genvar j = 0; j < MAX_TERMS; j++) begin : g_rk
      assign recip_tab[m][j] = IW'(recip(m != 0, j, FRAC));
    end
  end

  assign x_ext    = IW'(x_q);
  assign init_val = (mode_q == MODE_COS) ? ONE : x_ext;
  assign coef     = recip_tab[mode_q][k_q];

  trig_taylor_mac #(
    .IW   (IW),
    .FRAC (FRAC)
  ) u_mac (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .op_i   (mac_op),
    .x_i    (x_ext),
    .init_i (init_val),
    .coef_i (coef),
    .sum_o  (sum)
  );

  always_comb begin
    if (sum > SAT_HI)      sat_val = SAT_HI[W-1:0];
    else if (sum < SAT_LO) sat_val = SAT_LO[W-1:0];
    else                   sat_val = sum[W-1:0];
  end

  always_comb begin
    state_d = state_q;
    mac_op  = OP_HOLD;
    case (state_q)
      IDLE: if (start_i) state_d = SQ;
      SQ: begin
        mac_op  = OP_LOAD;
        state_d = MULX;
      end
      MULX: begin
        mac_op  = OP_MULX;
        state_d = MULR;
      end
      MULR: begin
        mac_op  = OP_MULR;
        state_d = ACC;
      end
      ACC: begin
        // Odd terms of both series carry a negative sign.
        mac_op  = k_q[0] ? OP_SUB : OP_ADD;
        state_d = (k_q == K_LAST) ? DONE : MULX;
      end
      DONE: if (valid_q && ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= IDLE;
      mode_q   <= MODE_SIN;
      x_q      <= '0;
      k_q      <= '0;
      valid_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start_i) begin
        x_q    <= x_i;
        mode_q <= mode_t'(mode_i);
      end
      if (state_q == SQ) begin
        k_q <= KW'(1);
      end else if (state_q == ACC && k_q != K_LAST) begin
        k_q <= k_q + KW'(1);
      end
      // Result is captured once on DONE entry so it stays frozen under back-pressure.
      if (state_q == DONE && !valid_q) begin
        valid_q  <= 1'b1;
        result_q <= sat_val;
      end else if (valid_q && ready_i) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign ready_o  = (state_q == IDLE);
  assign valid_o  = valid_q;
  assign result_o = result_q;

endmodule

// File: tb/tb_trig_taylor.sv
// tb/tb_trig_taylor.sv - self-checking bench for trig_taylor (NTERMS=4 and NTERMS=2 builds)
module tb_trig_taylor;

  localparam int F = 14;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  logic        start4, mode4, rdy4, ready4, valid4;
  logic [15:0] x4, res4;
  logic        start2, mode2, rdy2, ready2, valid2;
  logic [15:0] x2, res2;

  int total = 0;
  int bad   = 0;

  trig_taylor #(.W(16), .FRAC(14), .NTERMS(4), .GUARD(4)) dut (
    .clk_i(clk), .rstn_i(rstn), .start_i(start4), .mode_i(mode4), .x_i(x4),
    .ready_o(ready4), .result_o(res4), .valid_o(valid4), .ready_i(rdy4)
  );

  trig_taylor #(.W(16), .FRAC(14), .NTERMS(2), .GUARD(4)) dut2 (
    .clk_i(clk), .rstn_i(rstn), .start_i(start2), .mode_i(mode2), .x_i(x2),
    .ready_o(ready2), .result_o(res2), .valid_o(valid2), .ready_i(rdy2)
  );

  task automatic chk(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_tol(input string tag, input longint obs, input longint exp, input longint tol);
    logic ok;
    ok = (obs >= exp - tol) && (obs <= exp + tol);
    total++;
    assert (ok === 1'b1) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d+-%0d", tag, obs, exp, tol);
    end
  endtask

  // Plain-integer evaluation of the truncated series with floor-shift products.
  function automatic longint model(input int nt, input logic m, input longint x);
    longint xx, term, sum, d, rc;
    xx   = (x * x) >>> F;
    term = m ? (longint'(1) << F) : x;
    sum  = term;
    for (int k = 1; k < nt; k++) begin
      d    = m ? longint'((2 * k - 1) * (2 * k)) : longint'((2 * k) * (2 * k + 1));
      rc   = longint'($floor(real'(longint'(1) << F) / real'(d) + 0.5));
      term = (term * xx) >>> F;
      term = (term * rc) >>> F;
      sum  = (k % 2 == 1) ? sum - term : sum + term;
    end
    if (sum > 32767)  sum = 32767;
    if (sum < -32768) sum = -32768;
    return sum;
  endfunction

  // Called on a falling edge; returns on the falling edge after the result handshake.
  task automatic req(input int which, input logic m, input logic signed [15:0] x,
                     output longint res, output int lat);
    chk("issue_ready", (which == 4) ? ready4 : ready2, 1);
    if (which == 4) begin start4 = 1'b1; mode4 = m; x4 = x; end
    else            begin start2 = 1'b1; mode2 = m; x2 = x; end
    @(negedge clk);
    start4 = 1'b0;
    start2 = 1'b0;
    chk("ready_fall", (which == 4) ? ready4 : ready2, 0);
    lat = 0;
    while (!((which == 4) ? valid4 : valid2) && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    res = longint'($signed((which == 4) ? res4 : res2));
    @(negedge clk);
    chk("valid_drop", (which == 4) ? valid4 : valid2, 0);
    chk("ready_rise", (which == 4) ? ready4 : ready2, 1);
    chk("result_hold", longint'($signed((which == 4) ? res4 : res2)), res);
  endtask

  initial begin
    longint              r, held;
    int                  lat;
    logic                m, seen;
    logic signed [15:0]  xr;

    rstn = 1'b0;
    start4 = 1'b0; mode4 = 1'b0; x4 = '0; rdy4 = 1'b1;
    start2 = 1'b0; mode2 = 1'b0; x2 = '0; rdy2 = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready", ready4, 1);
    chk("rst_valid", valid4, 0);
    chk("rst_result", longint'(res4), 0);
    rstn = 1'b1;
    @(negedge clk);

    req(4, 1'b0, 16'sd0, r, lat);
    chk("sin0_latency", lat, 11);
    chk("sin0", r, 0);
    req(4, 1'b1, 16'sd0, r, lat);
    chk("cos0", r, 16384);
    req(4, 1'b0, 16'sd8192, r, lat);
    chk_tol("sin_half", r, 7855, 2);
    chk("sin_half_model", r, model(4, 1'b0, 8192));
    req(4, 1'b0, -16'sd8192, r, lat);
    chk_tol("sin_neg_half", r, -7855, 2);
    req(4, 1'b1, 16'sd16384, r, lat);
    chk_tol("cos_one", r, 8852, 3);
    chk("cos_one_model", r, model(4, 1'b1, 16384));
    req(4, 1'b0, -16'sd32768, r, lat);
    chk_tol("sin_neg_two", r, -14875, 4);
    chk("sin_neg_two_model", r, model(4, 1'b0, -32768));

    for (int i = 0; i < 24; i++) begin
      m  = 1'($urandom_range(0, 1));
      xr = 16'($urandom());
      req(4, m, xr, r, lat);
      chk("rand_latency", lat, 11);
      chk("rand_result", r, model(4, m, longint'(xr)));
    end

    // Back-pressure with ignored start pulses while DONE is held.
    rdy4 = 1'b0;
    start4 = 1'b1; mode4 = 1'b1; x4 = 16'sd4096;
    @(negedge clk);
    start4 = 1'b0;
    lat = 0;
    while (!valid4 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("bp_latency", lat, 11);
    held = longint'($signed(res4));
    chk("bp_result", held, model(4, 1'b1, 4096));
    for (int i = 0; i < 5; i++) begin
      start4 = 1'b1; mode4 = 1'b0; x4 = 16'($urandom());
      @(negedge clk);
      start4 = 1'b0;
      chk("bp_valid", valid4, 1);
      chk("bp_stable", longint'($signed(res4)), held);
      chk("bp_ready", ready4, 0);
    end
    rdy4 = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", valid4, 0);
    chk("bp_release_ready", ready4, 1);
    seen = 1'b0;
    repeat (14) begin
      @(negedge clk);
      seen = seen | valid4 | ~ready4;
    end
    chk("bp_nothing_queued", seen, 0);

    // Reset while the first term is in MULR.
    start4 = 1'b1; mode4 = 1'b0; x4 = 16'sd12000;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("abort_ready", ready4, 1);
    chk("abort_valid", valid4, 0);
    chk("abort_result", longint'(res4), 0);
    @(negedge clk);
    rstn = 1'b1;
    seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      seen = seen | valid4;
    end
    chk("abort_no_valid", seen, 0);
    xr = 16'($urandom());
    req(4, 1'b1, xr, r, lat);
    chk("post_abort", r, model(4, 1'b1, longint'(xr)));

    // Two-term build, issued back to back.
    req(2, 1'b0, 16'sd8192, r, lat);
    chk("n2_latency", lat, 5);
    chk_tol("n2_sin_half", r, 7851, 2);
    chk("n2_sin_half_model", r, model(2, 1'b0, 8192));
    for (int i = 0; i < 8; i++) begin
      m  = 1'($urandom_range(0, 1));
      xr = 16'($urandom());
      req(2, m, xr, r, lat);
      chk("n2_rand_latency", lat, 5);
      chk("n2_rand_result", r, model(2, m, longint'(xr)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
